// File: rtl/write_update_arbiter_if.sv
// write_update_arbiter_if
//   Bundles the requester-side and downstream-side handshake signals of the
//   write/update arbiter.
//   slave  : arbiter view (consumes requests, produces the downstream word)
//   master : environment view (requesters plus downstream node-update writer)
//   Requester payloads are packed: slice i = bits [i*W_D +: W_D].
interface write_update_arbiter_if #(
  parameter int W_D     = 32,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*W_D-1:0] req_addr;
  logic [NUM_REQ*W_D-1:0] req_cost;
  logic [NUM_REQ*W_D-1:0] req_parent;
  logic [W_D-1:0]         write_addr;
  logic                   write_valid;
  logic                   write_ready;
  logic [W_D-1:0]         next_cost;
  logic [W_D-1:0]         parent_addr;
  logic                   write_empty;

  modport slave (
    input  req_valid, req_addr, req_cost, req_parent, write_ready, write_empty,
    output req_ready, write_addr, write_valid, next_cost, parent_addr
  );

  modport master (
    output req_valid, req_addr, req_cost, req_parent, write_ready, write_empty,
    input  req_ready, write_addr, write_valid, next_cost, parent_addr
  );
endinterface

// File: rtl/write_update_arbiter.sv
// write_update_arbiter
//   Round-robin arbiter that collects node-update writes from NUM_REQ
//   requesters into a single registered output word for a downstream writer,
//   with a drain handshake for quiescing and a saturating issue counter.
// Ports
//   clk         : single clock, rising edge
//   rst_n       : asynchronous assert, active-low reset
//   bus         : requester and downstream handshakes (slave modport)
//   drain_req   : level request to quiesce
//   drain_done  : high while quiesced
//   issue_count : downstream transfers since reset or clear (saturating)
//   count_clear : synchronous counter clear
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal operation, requests accepted into the output register
// ST_DRAIN | no new accepts; pending word flushes, quiet window counts up
// ST_DONE  | quiesced, drain_done high until drain_req drops
module write_update_arbiter #(
  parameter int W_D     = 32,
  parameter int NUM_REQ = 4,
  parameter int W_CNT   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  write_update_arbiter_if.slave     bus,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic [W_CNT-1:0]          issue_count,
  input  logic                      count_clear
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [W_D-1:0]     addr_q, addr_d;
  logic [W_D-1:0]     cost_q, cost_d;
  logic [W_D-1:0]     parent_q, parent_d;
  logic               valid_q, valid_d;
  logic [1:0]         quiet_q, quiet_d;
  logic [W_CNT-1:0]   cnt_q, cnt_d;

  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic               load_en;
  logic               accept;
  logic               xfer;

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [PTR_W-1:0] cand;
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // rst_n gates the load enable so req_ready is forced low while reset is held.
  assign load_en = rst_n && (state_q == ST_RUN) && (!valid_q || bus.write_ready);
  assign accept  = load_en && grant_any;
  assign xfer    = valid_q && bus.write_ready;

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = accept && (grant_idx == PTR_W'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    cost_d   = cost_q;
    parent_d = parent_q;
    valid_d  = valid_q;
    quiet_d  = quiet_q;
    cnt_d    = cnt_q;

    if (accept) begin
      valid_d  = 1'b1;
      rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_idx == PTR_W'(i)) begin
          addr_d   = bus.req_addr[i*W_D +: W_D];
          cost_d   = bus.req_cost[i*W_D +: W_D];
          parent_d = bus.req_parent[i*W_D +: W_D];
        end
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    // Quiet window gives the downstream writer time to reflect an enqueue
    // on write_empty before the drain is declared complete.
    if (xfer || state_q == ST_RUN) begin
      quiet_d = 2'd0;
    end else if (state_q == ST_DRAIN && quiet_q != 2'd2) begin
      quiet_d = quiet_q + 2'd1;
    end

    if (count_clear) begin
      cnt_d = xfer ? W_CNT'(1) : '0;
    end else if (xfer && cnt_q != '1) begin
      cnt_d = cnt_q + W_CNT'(1);
    end

    case (state_q)
      ST_RUN: begin
        if (drain_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req) begin
          state_d = ST_RUN;
        end else if (!valid_q && bus.write_empty && quiet_q == 2'd2) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!drain_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      cost_q   <= '0;
      parent_q <= '0;
      valid_q  <= 1'b0;
      quiet_q  <= 2'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      cost_q   <= cost_d;
      parent_q <= parent_d;
      valid_q  <= valid_d;
      quiet_q  <= quiet_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.write_addr  = addr_q;
  assign bus.next_cost   = cost_q;
  assign bus.parent_addr = parent_q;
  assign bus.write_valid = valid_q;
  assign drain_done      = (state_q == ST_DONE);
  assign issue_count     = cnt_q;

endmodule

// File: tb/tb_write_update_arbiter.sv
module tb_write_update_arbiter;
  localparam int W_D     = 32;
  localparam int NUM_REQ = 4;
  localparam int W_CNT   = 4;

  logic             clk;
  logic             rst_n;
  logic             drain_req;
  logic             drain_done;
  logic [W_CNT-1:0] issue_count;
  logic             count_clear;

  write_update_arbiter_if #(.W_D(W_D), .NUM_REQ(NUM_REQ)) bus ();

  write_update_arbiter #(.W_D(W_D), .NUM_REQ(NUM_REQ), .W_CNT(W_CNT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .drain_req   (drain_req),
    .drain_done  (drain_done),
    .issue_count (issue_count),
    .count_clear (count_clear)
  );

  typedef struct {
    logic [W_D-1:0] a;
    logic [W_D-1:0] c;
    logic [W_D-1:0] p;
  } word_t;

  word_t          exp_q[$];
  logic [W_D-1:0] a_tbl[NUM_REQ];
  logic [W_D-1:0] c_tbl[NUM_REQ];
  logic [W_D-1:0] p_tbl[NUM_REQ];
  int             n_checks = 0;
  int             n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fill(input logic [W_D-1:0] base);
    for (int i = 0; i < NUM_REQ; i++) begin
      a_tbl[i] = base + W_D'(i);
      c_tbl[i] = base + 32'h100 + W_D'(i);
      p_tbl[i] = base + 32'h200 + W_D'(i);
      bus.req_addr[i*W_D +: W_D]   = a_tbl[i];
      bus.req_cost[i*W_D +: W_D]   = c_tbl[i];
      bus.req_parent[i*W_D +: W_D] = p_tbl[i];
    end
  endtask

  task automatic push(input int i);
    word_t w;
    w.a = a_tbl[i];
    w.c = c_tbl[i];
    w.p = p_tbl[i];
    exp_q.push_back(w);
  endtask

  // Scoreboard monitor: a transfer happens at the next rising edge whenever
  // write_valid && write_ready are seen on the falling edge.
  always @(negedge clk) begin
    if (rst_n && bus.write_valid && bus.write_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL xfer_unexpected: got addr %0h expected no transfer", bus.write_addr);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        check("xfer_addr",   64'(bus.write_addr),  64'(e.a));
        check("xfer_cost",   64'(bus.next_cost),   64'(e.c));
        check("xfer_parent", 64'(bus.parent_addr), 64'(e.p));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b1;
    drain_req       = 1'b0;
    count_clear     = 1'b0;
    bus.req_valid   = '1;
    bus.write_ready = 1'b0;
    bus.write_empty = 1'b1;
    fill(32'h100);
    #1 rst_n = 1'b0;
    #1;
    // reset values
    check("rst_write_valid", 64'(bus.write_valid), 0);
    check("rst_write_addr",  64'(bus.write_addr),  0);
    check("rst_next_cost",   64'(bus.next_cost),   0);
    check("rst_parent_addr", 64'(bus.parent_addr), 0);
    check("rst_req_ready",   64'(bus.req_ready),   0);
    check("rst_drain_done",  64'(drain_done),      0);
    check("rst_issue_count", 64'(issue_count),     0);
    tick();
    tick();
    rst_n = 1'b1;

    // round-robin with all requesters valid and downstream always ready
    bus.write_ready = 1'b1;
    bus.req_valid   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_req_ready", 64'(bus.req_ready), 64'(1) << (k % 4));
      push(k % 4);
      tick();
    end
    check("rr_count4", 64'(issue_count), 4);
    bus.req_valid = '0;
    tick();
    check("rr_count5", 64'(issue_count), 5);
    check("rr_valid_clear", 64'(bus.write_valid), 0);

    // stall: only requester 2, downstream not ready for 3 cycles
    fill(32'h0);
    a_tbl[2] = 32'h10;
    bus.req_addr[2*W_D +: W_D] = 32'h10;
    bus.write_ready = 1'b0;
    bus.req_valid   = 4'b0100;
    #1;
    check("stall_grant2", 64'(bus.req_ready), 4'b0100);
    push(2);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_valid", 64'(bus.write_valid), 1);
      check("stall_addr",  64'(bus.write_addr),  32'h10);
      check("stall_ready", 64'(bus.req_ready),   0);
      check("stall_count", 64'(issue_count),     5);
      tick();
    end
    bus.req_valid   = '0;
    bus.write_ready = 1'b1;
    tick();
    check("stall_done_valid", 64'(bus.write_valid), 0);
    check("stall_done_count", 64'(issue_count),     6);

    // drain with one pending word and a slow write_empty
    fill(32'h500);
    bus.write_ready = 1'b0;
    bus.write_empty = 1'b0;
    bus.req_valid   = 4'b0001;
    drain_req       = 1'b1;
    #1;
    check("drain_same_cycle_accept", 64'(bus.req_ready), 4'b0001);
    push(0);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_no_accept", 64'(bus.req_ready),   0);
      check("drain_pending",   64'(bus.write_valid), 1);
      check("drain_not_done",  64'(drain_done),      0);
      tick();
    end
    bus.write_empty = 1'b1;
    bus.write_ready = 1'b1;
    #1;
    check("drain_done_pre", 64'(drain_done), 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_flushed",   64'(bus.write_valid), 0);
      check("drain_no_accept", 64'(bus.req_ready),   0);
      check("drain_done_seq",  64'(drain_done),      (k == 3) ? 1 : 0);
      tick();
    end
    #1;
    check("done_hold", 64'(drain_done), 1);
    check("done_no_accept", 64'(bus.req_ready), 0);
    drain_req     = 1'b0;
    bus.req_valid = '0;
    tick();
    check("done_release", 64'(drain_done), 0);
    check("drain_count", 64'(issue_count), 7);

    // drain abandoned in DRAIN returns to RUN
    drain_req = 1'b1;
    tick();
    drain_req     = 1'b0;
    bus.req_valid = 4'b0010;
    #1;
    check("abort_no_accept", 64'(bus.req_ready), 0);
    tick();
    #1;
    check("abort_run_grant1", 64'(bus.req_ready), 4'b0010);
    push(1);
    tick();
    bus.req_valid = '0;
    tick();
    check("abort_count", 64'(issue_count), 8);

    // counter clear alone, then saturation at 15
    count_clear = 1'b1;
    tick();
    count_clear = 1'b0;
    check("clear_alone", 64'(issue_count), 0);
    fill(32'h1000);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      #1;
      check("sat_req_ready", 64'(bus.req_ready), 64'(1) << ((2 + k) % 4));
      push((2 + k) % 4);
      tick();
    end
    check("sat_reach15", 64'(issue_count), 15);
    bus.req_valid = '0;
    tick();
    check("sat_stay15", 64'(issue_count), 15);

    // clear coinciding with a transfer
    bus.req_valid = 4'b0100;
    #1;
    check("clrx_grant2", 64'(bus.req_ready), 4'b0100);
    push(2);
    tick();
    bus.req_valid = '0;
    count_clear   = 1'b1;
    tick();
    count_clear = 1'b0;
    check("clear_with_xfer", 64'(issue_count), 1);

    // asynchronous reset while a word is stalled
    fill(32'h7000);
    bus.write_ready = 1'b0;
    bus.req_valid   = 4'b0010;
    #1;
    check("rst_mid_grant1", 64'(bus.req_ready), 4'b0010);
    tick();
    check("rst_mid_pending", 64'(bus.write_valid), 1);
    rst_n = 1'b0;
    #1;
    check("arst_write_valid", 64'(bus.write_valid), 0);
    check("arst_write_addr",  64'(bus.write_addr),  0);
    check("arst_next_cost",   64'(bus.next_cost),   0);
    check("arst_parent_addr", 64'(bus.parent_addr), 0);
    check("arst_req_ready",   64'(bus.req_ready),   0);
    check("arst_issue_count", 64'(issue_count),     0);
    check("arst_drain_done",  64'(drain_done),      0);
    tick();
    rst_n           = 1'b1;
    bus.write_ready = 1'b1;
    bus.req_valid   = 4'b1111;
    #1;
    check("post_rst_grant0", 64'(bus.req_ready), 4'b0001);
    push(0);
    tick();
    bus.req_valid = '0;
    tick();
    check("post_rst_count", 64'(issue_count), 1);
    tick();
    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/write_update_arbiter.md
WRITE_UPDATE_ARBITER -- requirements
Module: write_update_arbiter

Interface
REQ-001 SHALL have parameter W_D, default 32: width of address, cost and parent words.
REQ-002 SHALL have parameter NUM_REQ, default 4, legal range 2..8: number of requesters.
REQ-003 SHALL have parameter W_CNT, default 32: width of issue counter.
REQ-004 CLK  input  1  single clock, all state on rising edge.
REQ-005 RST  input  1  reset, asynchronous assert, active-low; synchronous deassert.
REQ-006 req_valid  input  NUM_REQ  per-requester write request.
REQ-007 req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 req_addr  input  NUM_REQ*W_D  packed node addresses; slice i = bits [i*W_D +: W_D].
REQ-009 req_cost  input  NUM_REQ*W_D  packed next_cost values, same packing.
REQ-010 req_parent  input  NUM_REQ*W_D  packed parent_addr values, same packing.
REQ-011 write_addr  output  W_D  to downstream node-update writer.
REQ-012 write_valid  output  1  downstream request.
REQ-013 write_ready  input  1  downstream accept.
REQ-014 next_cost  output  W_D  to downstream.
REQ-015 parent_addr  output  W_D  to downstream.
REQ-016 write_empty  input  1  downstream command channel empty.
REQ-017 drain_req  input  1  level request to quiesce.
REQ-018 drain_done  output  1  quiesced indication.
REQ-019 issue_count  output  W_CNT  downstream transfers since reset or clear.
REQ-020 count_clear  input  1  synchronous counter clear.

Function
REQ-021 Output stage: single register {write_addr, next_cost, parent_addr, write_valid}; write_valid driven directly from the register.
REQ-022 Transfer: write_valid && write_ready; register SHALL hold value stable while write_valid && !write_ready.
REQ-023 Load enable: state RUN && (!write_valid || write_ready); req_ready[i] = load enable && grant[i].
REQ-024 Grant: combinational round-robin over req_valid, searching from index rr_ptr upward modulo NUM_REQ; at most one grant.
REQ-025 On accept of requester i: register loads slice i, write_valid=1 next cycle, rr_ptr <= (i+1) mod NUM_REQ; rr_ptr unchanged when no accept.
REQ-026 Latency: accept in cycle t -> write_valid with that data in cycle t+1; full throughput of one word/cycle while write_ready=1.
REQ-027 Transfer without new accept in the same cycle SHALL clear write_valid; transfer with accept reloads (back-to-back).
REQ-028 FSM states RUN, DRAIN, DONE.
REQ-029 RUN -> DRAIN when drain_req=1; accepts remain legal in that same cycle.
REQ-030 DRAIN: no accepts (req_ready=0); pending register still transfers.
REQ-031 quiet counter (2-bit, saturating at 2): reset to 0 on any transfer or in RUN, else increments in DRAIN.
REQ-032 DRAIN -> DONE when !write_valid && write_empty && quiet==2; covers downstream enqueue delay.
REQ-033 DONE: drain_done=1, no accepts; DONE -> RUN when drain_req=0; drain_done=0 in all other states.
REQ-034 drain_req deasserted while in DRAIN SHALL return FSM to RUN next cycle.
REQ-035 issue_count: +1 per transfer, saturates at 2^W_CNT-1; count_clear with transfer in same cycle -> 1; count_clear alone -> 0.
REQ-036 req_valid of a requester SHALL not be required to stay asserted; a dropped request is simply not granted.

Reset
REQ-037 RST low SHALL immediately force: write_valid=0, write_addr/next_cost/parent_addr=0, rr_ptr=0, FSM=RUN, quiet=0, issue_count=0, drain_done=0, req_ready=0.
REQ-038 Reset mid-transfer SHALL discard the held word; no recovery of it required.

Verification
REQ-039 req_valid=4'b1111, write_ready=1 constant -> grants 0,1,2,3,0 on consecutive cycles; issue_count=4 after 5 cycles from first accept.
REQ-040 req_valid[2] only, addr=0x10, write_ready=0 for 3 cycles -> write_valid=1 with addr 0x10 held 3 cycles, req_ready=0 those cycles, one transfer when ready rises.
REQ-041 one word pending, drain_req=1, write_empty=0 for 4 cycles then 1 -> no accepts, drain_done=1 exactly 3 cycles after write_empty and !write_valid both hold (quiet reaches 2 then DONE), clears 1 cycle after drain_req=0.
REQ-042 issue_count preset to 2^W_CNT-1 (W_CNT=4, 15) plus transfer -> stays 15; count_clear with simultaneous transfer -> 1.
REQ-043 RST low during write_valid=1 && write_ready=0 -> all outputs 0 asynchronously; after release, first grant goes to requester 0.
